// File: rtl/func_logic_pkg.sv
// ---------------------------------------------------------------------------
// func_logic_pkg
// Shared types and constants for the func_logic 4-input LUT cell.
//   TT_W            : truth-table width (one bit per input combination)
//   func_idx_t      : 4-bit LUT index, {a,b,c,d} with a as the MSB
//   func_tt_t       : 16-bit truth table, bit i is the output for index i
//   FUNC_TT_DEFAULT : table loaded at reset, y = (a & ~b) | (c & d)
// ---------------------------------------------------------------------------
package func_logic_pkg;

    localparam int TT_W = 16;

    typedef logic [3:0]      func_idx_t;
    typedef logic [TT_W-1:0] func_tt_t;

    localparam func_tt_t FUNC_TT_DEFAULT = 16'h8F88;

endpackage : func_logic_pkg

// File: rtl/func_lut.sv
// ---------------------------------------------------------------------------
// func_lut
// Purely combinational 16:1 table lookup. It has no state. The parent module
// registers the result.
// Ports:
//   idx : input  func_idx_t, selects one truth-table bit
//   tt  : input  func_tt_t,  the active truth table
//   val : output 1-bit,      tt[idx]
// ---------------------------------------------------------------------------
module func_lut
    import func_logic_pkg::*;
(
    input  func_idx_t idx,
    input  func_tt_t  tt,
    output logic      val
);

    // Select the table bit for the current input combination.
    assign val = tt[idx];

endmodule : func_lut

// File: rtl/func_logic.sv
// ---------------------------------------------------------------------------
// func_logic
// Registered 4-input Boolean function evaluator built around a 16-entry LUT
// that can be reprogrammed at run time.
// Parameters:
//   TT_DEFAULT : truth table restored by reset
//   CNT_W      : hit counter width (only with FUNC_HIT_CNT_EN)
// Ports:
//   clk      : input,  system clock, rising edge
//   rst      : input,  asynchronous active-high reset
//   a,b,c,d  : input,  function inputs, index = {a,b,c,d}
//   tt_we    : input,  one-cycle truth-table write strobe
//   tt_wdata : input,  new truth table (same bit order as TT_DEFAULT)
//   y        : output, registered function result (1-cycle latency)
//   hit_cnt  : output, saturating count of cycles with y=1
//              (only with FUNC_HIT_CNT_EN)
// Configuration macro: FUNC_HIT_CNT_EN adds the hit counter and its port.
// ---------------------------------------------------------------------------
module func_logic
    import func_logic_pkg::*;
#(
    parameter func_tt_t TT_DEFAULT = FUNC_TT_DEFAULT
`ifdef FUNC_HIT_CNT_EN
    ,
    parameter int       CNT_W      = 8
`endif
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             tt_we,
    input  func_tt_t         tt_wdata,
`ifdef FUNC_HIT_CNT_EN
    output logic [CNT_W-1:0] hit_cnt,
`endif
    output logic             y
);

    func_tt_t  r_ttReg;
    logic      r_y;
    func_idx_t w_idx;
    logic      w_lutOut;

    assign w_idx = {a, b, c, d};

    // Combinational lookup into the current (pre-write) table.
    func_lut u_lut (
        .idx (w_idx),
        .tt  (r_ttReg),
        .val (w_lutOut)
    );

    // Truth-table storage. A write takes effect on the edge it is sampled.
    // The lookup feeding r_y on that same edge still sees the old contents,
    // so the new table first affects y on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ttReg <= TT_DEFAULT;
        end else if (tt_we) begin
            r_ttReg <= tt_wdata;
        end
    end

    // Output register. This keeps a full clock of latency between the inputs
    // and y, and there is no combinational path from the inputs to y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_lutOut;
        end
    end

    assign y = r_y;

`ifdef FUNC_HIT_CNT_EN
    logic [CNT_W-1:0] r_hitCnt;

    // Count edges where the value being registered into y is 1. w_lutOut is
    // that value. The counter sticks at all-ones rather than wrapping. Only
    // reset clears it; table writes leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hitCnt <= '0;
        end else if (w_lutOut && (r_hitCnt != {CNT_W{1'b1}})) begin
            r_hitCnt <= r_hitCnt + CNT_W'(1);
        end
    end

    assign hit_cnt = r_hitCnt;
`endif

endmodule : func_logic

// File: tb/tb_func_logic.sv
// ---------------------------------------------------------------------------
// tb_func_logic
// Self-checking bench for func_logic. Expected y values are queued as each
// vector is driven. They are popped and compared one edge later.
// Configuration macro: FUNC_HIT_CNT_EN also exercises the hit counter.
// ---------------------------------------------------------------------------
module tb_func_logic;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        a        = 1'b0;
    logic        b        = 1'b0;
    logic        c        = 1'b0;
    logic        d        = 1'b0;
    logic        tt_we    = 1'b0;
    logic [15:0] tt_wdata = 16'h0000;
    logic        y;
`ifdef FUNC_HIT_CNT_EN
    logic [7:0]  hit_cnt;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    // Expected y per input index for the reset-default function.
    int defaultY [16] = '{0,0,0,1,0,0,0,1,1,1,1,1,0,0,0,1};

    bit          expQ[$];
    logic [15:0] modelTt = 16'h8F88;

    func_logic u_dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .tt_we    (tt_we),
        .tt_wdata (tt_wdata),
`ifdef FUNC_HIT_CNT_EN
        .hit_cnt  (hit_cnt),
`endif
        .y        (y)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one vector at the falling edge and queue its expected y. If
    // forceExp is 0 or 1, it overrides the table model. The write updates the
    // model only after the expectation is queued, because the edge that
    // samples the write still evaluates with the old table. After the rising
    // edge, pop the expectation and compare.
    task automatic applyStimulus(input logic [3:0] idx, input logic we,
                                 input logic [15:0] wdata, input int forceExp,
                                 input string tag);
        bit expY;
        @(negedge clk);
        {a, b, c, d} = idx;
        tt_we        = we;
        tt_wdata     = wdata;
        if (forceExp >= 0) expQ.push_back(forceExp[0]);
        else               expQ.push_back(modelTt[idx]);
        if (we) modelTt = wdata;
        @(posedge clk);
        #1;
        tt_we = 1'b0;
        expY  = expQ.pop_front();
        checkOutput(tag, {31'd0, y}, {31'd0, expY});
    endtask

    // Assert reset at a falling edge, confirm the cleared outputs, then release.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstY", {31'd0, y}, 32'd0);
`ifdef FUNC_HIT_CNT_EN
        checkOutput("rstHit", {24'd0, hit_cnt}, 32'd0);
`endif
        modelTt = 16'h8F88;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset is asserted from time 0.
        #2;
        checkOutput("initY", {31'd0, y}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: exhaustive sweep of the default function
        for (int i = 0; i < 16; i++)
            applyStimulus(4'(i), 1'b0, 16'h0000, defaultY[i], "defSweep");

        // 2: program parity. The write edge still uses the old table.
        applyStimulus(4'b0001, 1'b1, 16'h6996, 0, "wrOld");
        applyStimulus(4'b0001, 1'b0, 16'h0000, 1, "wrNew");
        for (int i = 0; i < 16; i++)
            applyStimulus(4'(i), 1'b0, 16'h0000, int'(^(4'(i))), "parSweep");

        // 3: async reset between edges while y=1
        applyStimulus(4'd2, 1'b1, 16'hFFFF, -1, "ffWrite");
        applyStimulus(4'd5, 1'b0, 16'h0000, 1, "ffHigh");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstY", {31'd0, y}, 32'd0);
        modelTt = 16'h8F88;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'd4, 1'b0, 16'h0000, 0, "defRestored");

        // 4: back-to-back writes, last one wins
        applyStimulus(4'd0, 1'b1, 16'h0000, -1, "b2bFirst");
        applyStimulus(4'd0, 1'b1, 16'hFFFF, -1, "b2bSecond");
        for (int i = 0; i < 16; i++)
            applyStimulus(4'(i), 1'b0, 16'h0000, 1, "onesSweep");

`ifdef FUNC_HIT_CNT_EN
        // 5: hit counter saturation, clear and default-sweep count
        for (int i = 0; i < 300; i++)
            applyStimulus(4'(i), 1'b0, 16'h0000, 1, "holdOnes");
        checkOutput("hitSat", {24'd0, hit_cnt}, 32'd255);
        doReset();
        for (int i = 0; i < 16; i++)
            applyStimulus(4'(i), 1'b0, 16'h0000, defaultY[i], "hitSweep");
        checkOutput("hitDefault", {24'd0, hit_cnt}, 32'd7);
`else
        doReset();
        applyStimulus(4'd3, 1'b0, 16'h0000, 1, "postRst");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule : tb_func_logic

// File: doc/func_logic.md
Name: func_logic

Overview:
- Registered 4-input Boolean function evaluator; inputs a, b, c, d; single-bit output y.
- The function is a 16-entry truth table (LUT).
  - The LUT resets to a fixed default function.
  - The LUT can be reprogrammed at run time through a one-cycle write strobe.
- Sits as a small glue-logic cell in the datapath; exhaustively testable over all 16 input combinations.

Parameters:
- TT_DEFAULT, 16'h8F88, truth table loaded at reset.
  - Bit i is the y value for index i = {a,b,c,d} (a is MSB).
  - Default implements y = (a & ~b) | (c & d).
- CNT_W, 8, width of the optional hit counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  1  function input, index bit 3
- b  in  1  function input, index bit 2
- c  in  1  function input, index bit 1
- d  in  1  function input, index bit 0
- tt_we  in  1  truth-table write strobe, one cycle
- tt_wdata  in  16  new truth table, same bit ordering as TT_DEFAULT
- y  out  1  registered function output
- hit_cnt  out  CNT_W  count of cycles with y=1; present only with FUNC_HIT_CNT_EN

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, named rst.
- While rst=1:
  - tt_reg = TT_DEFAULT
  - y = 0
  - hit_cnt = 0
- Evaluation:
  - idx = {a,b,c,d}; y <= tt_reg[idx] on every rising edge.
  - Latency is 1 cycle from input change to y; there is no combinational path from inputs to y.
- Default function results:
  - y=1 for idx 3, 7, 8, 9, 10, 11, 15.
  - y=0 for idx 0, 1, 2, 4, 5, 6, 12, 13, 14.
- Truth-table write:
  - tt_we=1 at edge N loads tt_reg <= tt_wdata.
  - The y computed at edge N uses the OLD table; the new table affects y from edge N+1.
  - Back-to-back writes are allowed; the last write wins.
- Input X/Z: not supported. Inputs are treated as 2-state; no X-propagation guarantee.
- Reset mid-operation: asynchronously restores TT_DEFAULT, discarding any programmed table, and forces y=0 immediately.
- First evaluation after reset release: y = TT_DEFAULT[idx] at the first rising edge with rst=0.
- Inputs a–d are sampled synchronously; they must be synchronous to clk.

Optional Feature:
- Macro FUNC_HIT_CNT_EN.
- Defined:
  - Port hit_cnt exists.
  - hit_cnt increments by 1 on each edge where the newly registered y is 1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by rst.
  - A table write does not clear it.
- Undefined:
  - hit_cnt port and counter logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package func_logic_pkg holds:
  - localparam TT_W = 16
  - typedef logic [3:0] func_idx_t
  - typedef logic [TT_W-1:0] func_tt_t
  - localparam func_tt_t FUNC_TT_DEFAULT = 16'h8F88, used as the TT_DEFAULT default
- One natural sub-module: func_lut.
  - Purely combinational; inputs func_idx_t idx and func_tt_t tt; output tt[idx].
  - Instantiated once by func_logic, with the output register in the parent.

Test Plan:
1. Reset then exhaustive sweep: assert rst, release, apply idx 0..15 one per cycle. y one cycle later must be 0,0,0,1,0,0,0,1,1,1,1,1,0,0,0,1.
2. Reprogram: write tt_wdata=16'h6996 (XOR parity) with abcd=0001 on the same edge.
   - y at that edge must be 0 (old table).
   - Next edge y=1.
   - Sweep: y must equal a^b^c^d for all 16 indices.
3. Async reset mid-run: with table 16'hFFFF and y=1, assert rst between edges.
   - y must go 0 immediately, without waiting for an edge.
   - After release, idx 4 must give y=0 (default restored).
4. Back-to-back writes: tt_we on two consecutive cycles with 16'h0000 then 16'hFFFF.
   - Subsequent sweep gives y=1 for all indices.
5. (FUNC_HIT_CNT_EN, CNT_W=8) Load 16'hFFFF and hold for 300 cycles: hit_cnt must saturate at 255.
   - Then rst must return hit_cnt to 0.
   - Default-table sweep of 16 indices must end with hit_cnt=7.
